// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: output-port stage that drains N_IN input FIFOs into one
// downstream FIFO through a single output register, using round-robin priority.
// Optional statistics counters are built when RR_ARB_STATS_EN is defined;
// otherwise grant_cnt and stall_cnt are tied to zero.

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 6
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 2
`endif

module rr_fifo_arbiter #(
  parameter int N_IN  = 4,
  parameter int WIDTH = `PAYLOAD_SIZE + `ADDR_BITS,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN-1:0]       in_empty,
  input  logic [N_IN*WIDTH-1:0] in_item,
  output logic [N_IN-1:0]       in_read,
  input  logic                  out_full,
  output logic [WIDTH-1:0]      out_item,
  output logic                  out_write,
  output logic [15:0]           grant_cnt,
  output logic [15:0]           stall_cnt
);

  // Distance from the pointer to input i, walking upward with wrap.
  function automatic int rr_dist(input int i, input logic [PTR_W-1:0] p);
    return (i - int'(p) + N_IN) % N_IN;
  endfunction

  // Pointer value following grant g, wrapping at N_IN-1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    if (int'(g) >= N_IN - 1) begin
      return '0;
    end else begin
      return g + PTR_W'(1);
    end
  endfunction

  logic             out_valid_r;
  logic [WIDTH-1:0] out_item_r;
  logic [PTR_W-1:0] rr_ptr_r;

  logic [N_IN-1:0]  req_s;
  logic             any_req_s;
  logic             xfer_s;
  logic             load_en_s;
  logic             pop_s;
  logic [PTR_W-1:0] grant_s;
  logic [WIDTH-1:0] sel_item_s;
  int               best_dist_s;

  assign out_write = out_valid_r;
  assign out_item  = out_item_r;

  // Handshake: the register frees up when empty or when its flit drains this cycle.
  // Pops are suppressed while reset is held so no flit is lost.
  always_comb begin
    req_s     = ~in_empty;
    any_req_s = |req_s;
    xfer_s    = out_valid_r & ~out_full;
    load_en_s = ~out_valid_r | xfer_s;
    pop_s     = load_en_s & any_req_s & reset;
  end

  // Round-robin pick: the requester closest to rr_ptr (upward, with wrap) wins.
  always_comb begin
    best_dist_s = N_IN;
    grant_s     = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (req_s[i] && (rr_dist(i, rr_ptr_r) < best_dist_s)) begin
        best_dist_s = rr_dist(i, rr_ptr_r);
        grant_s     = PTR_W'(i);
      end else begin
        best_dist_s = best_dist_s;
        grant_s     = grant_s;
      end
    end
  end

  // Decode the grant into the pop strobes and select the granted flit.
  always_comb begin
    in_read    = '0;
    sel_item_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_s == PTR_W'(i)) begin
        in_read[i] = pop_s;
        sel_item_s = in_item[i*WIDTH +: WIDTH];
      end else begin
        in_read[i] = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; a pop overwrites a draining flit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_item_r  <= '0;
      rr_ptr_r    <= '0;
    end else if (pop_s) begin
      out_valid_r <= 1'b1;
      out_item_r  <= sel_item_s;
      rr_ptr_r    <= next_ptr(grant_s);
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef RR_ARB_STATS_EN
  logic [15:0] grant_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating counters of forwarded flits and backpressured cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt_r <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else begin
      if (xfer_s && (grant_cnt_r != 16'hFFFF)) begin
        grant_cnt_r <= grant_cnt_r + 16'h0001;
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
      if (out_valid_r && out_full && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign grant_cnt = grant_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  assign grant_cnt = 16'h0000;
  assign stall_cnt = 16'h0000;
`endif

endmodule
